// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter
// Shares the configuration SPI flash between two masters. Requester 0 is the
// DFU SPI engine and requester 1 a secondary master. The owner's SPI pins pass
// straight through with no added latency. Chip-select is held high for a
// guard gap between owners. An owner that idles too long while the other side
// waits can be preempted.
//
// Handshake: reqN is a level request. gntN is registered and rises one cycle
// after arbitration in IDLE. The grantee keeps reqN high for as long as it
// wants the bus. It must keep spiN_csel high until it has seen gntN high.
// Dropping reqN releases the bus once spiN_csel is back high. A grant that
// falls while reqN is still high is a preemption (flagged by preempt), and the
// requester must drop reqN and ask again.
module spi_flash_arbiter #(
   parameter int GUARD_CYCLES = 4,
   parameter int IDLE_TIMEOUT = 4096
) (
   input  logic       clk_48mhz,
   input  logic       reset,
   input  logic       req0,
   output logic       gnt0,
   input  logic       spi0_csel,
   input  logic       spi0_clk,
   input  logic       spi0_mosi,
   output logic       spi0_miso,
   input  logic       req1,
   output logic       gnt1,
   input  logic       spi1_csel,
   input  logic       spi1_clk,
   input  logic       spi1_mosi,
   output logic       spi1_miso,
   output logic       spi_csel,
   output logic       spi_clk,
   output logic       spi_mosi,
   input  logic       spi_miso,
   output logic       busy,
   output logic       owner,
   output logic       preempt,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DRAIN = 2'd2,
      GUARD = 2'd3
   } state_t;

   // The timeout fires on the edge where the counter already holds
   // IDLE_TIMEOUT-1 waiting cycles and the current cycle is the last one.
   localparam logic        TIMEOUT_EN   = (IDLE_TIMEOUT != 0);
   localparam logic [15:0] TIMEOUT_LAST = 16'(IDLE_TIMEOUT - 1);
   localparam logic [7:0]  GUARD_LAST   = 8'(GUARD_CYCLES - 1);

   state_t      state, state_nx;
   logic        owner_q, owner_nx;
   logic        last_owner, last_owner_nx;
   logic        gnt0_nx, gnt1_nx, preempt_nx;
   logic [15:0] to_cnt, to_cnt_nx;
   logic [7:0]  guard_cnt, guard_cnt_nx;

   logic own_req, other_req, own_csel, own_clk, own_mosi;
   logic bus_on;
   logic waiting;

   assign own_req   = owner_q ? req1      : req0;
   assign other_req = owner_q ? req0      : req1;
   assign own_csel  = owner_q ? spi1_csel : spi0_csel;
   assign own_clk   = owner_q ? spi1_clk  : spi0_clk;
   assign own_mosi  = owner_q ? spi1_mosi : spi0_mosi;

   // The owner sits idle with csel high while the other requester is queued.
   assign waiting = TIMEOUT_EN && other_req && own_csel;

   // State register and registered outputs; reset forces the bus idle at once.
   always_ff @(posedge clk_48mhz or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         owner_q    <= 1'b0;
         last_owner <= 1'b1;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         preempt    <= 1'b0;
         to_cnt     <= '0;
         guard_cnt  <= '0;
      end else begin
         state      <= state_nx;
         owner_q    <= owner_nx;
         last_owner <= last_owner_nx;
         gnt0       <= gnt0_nx;
         gnt1       <= gnt1_nx;
         preempt    <= preempt_nx;
         to_cnt     <= to_cnt_nx;
         guard_cnt  <= guard_cnt_nx;
      end
   end

   // Next-state logic: arbitration, release, timeout preemption and guard gap.
   always_comb begin
      state_nx      = state;
      owner_nx      = owner_q;
      last_owner_nx = last_owner;
      gnt0_nx       = 1'b0;
      gnt1_nx       = 1'b0;
      preempt_nx    = 1'b0;
      to_cnt_nx     = '0;
      guard_cnt_nx  = '0;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               // On a tie, the grant goes to whoever did not hold the bus last.
               if (req0 && req1) owner_nx = ~last_owner;
               else              owner_nx = req1;
               state_nx = GRANT;
               gnt0_nx  = ~owner_nx;
               gnt1_nx  = owner_nx;
            end
         end
         GRANT: begin
            if (!own_req) begin
               // A release takes priority over a timeout on the same edge.
               state_nx = DRAIN;
            end else if (waiting && (to_cnt == TIMEOUT_LAST)) begin
               // Safe to jump straight to GUARD: csel is known to be high.
               state_nx   = GUARD;
               preempt_nx = 1'b1;
            end else begin
               gnt0_nx = ~owner_q;
               gnt1_nx = owner_q;
               if (waiting) to_cnt_nx = to_cnt + 16'd1;
            end
         end
         DRAIN: begin
            if (own_csel) state_nx = GUARD;
         end
         GUARD: begin
            if (guard_cnt == GUARD_LAST) begin
               state_nx      = IDLE;
               last_owner_nx = owner_q;
            end else begin
               guard_cnt_nx = guard_cnt + 8'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Bus mux, driven only by registered state so that pass-through adds no latency.
   assign bus_on    = (state == GRANT) || (state == DRAIN);
   assign spi_csel  = bus_on ? own_csel : 1'b1;
   assign spi_clk   = bus_on ? own_clk  : 1'b0;
   assign spi_mosi  = bus_on ? own_mosi : 1'b0;
   assign spi0_miso = bus_on && !owner_q && spi_miso;
   assign spi1_miso = bus_on &&  owner_q && spi_miso;

   assign busy      = (state != IDLE);
   assign owner     = owner_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb_spi_flash_arbiter
// Randomized two-requester traffic against a timeline model of the arbiter.
// Grant and preempt events are queued by the model and matched by a monitor.
// Every cycle the monitor also compares all outputs against the model.
module tb_spi_flash_arbiter;

   localparam int GUARD = 4;
   localparam int TO    = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #10 clk = ~clk;

   logic [1:0] r_req  = 2'b00;
   logic [1:0] r_csel = 2'b11;
   logic [1:0] r_clk  = 2'b00;
   logic [1:0] r_mosi = 2'b00;
   logic       r_miso = 1'b0;

   logic       gnt0, gnt1, spi0_miso, spi1_miso;
   logic       spi_csel, spi_clk, spi_mosi, busy, owner, preempt;
   logic [1:0] state_dbg;
   logic [1:0] gnt_w;
   assign gnt_w = {gnt1, gnt0};

   spi_flash_arbiter #(.GUARD_CYCLES(GUARD), .IDLE_TIMEOUT(TO)) dut (
      .clk_48mhz (clk),
      .reset     (rst),
      .req0      (r_req[0]),
      .gnt0      (gnt0),
      .spi0_csel (r_csel[0]),
      .spi0_clk  (r_clk[0]),
      .spi0_mosi (r_mosi[0]),
      .spi0_miso (spi0_miso),
      .req1      (r_req[1]),
      .gnt1      (gnt1),
      .spi1_csel (r_csel[1]),
      .spi1_clk  (r_clk[1]),
      .spi1_mosi (r_mosi[1]),
      .spi1_miso (spi1_miso),
      .spi_csel  (spi_csel),
      .spi_clk   (spi_clk),
      .spi_mosi  (spi_mosi),
      .spi_miso  (r_miso),
      .busy      (busy),
      .owner     (owner),
      .preempt   (preempt),
      .state_dbg (state_dbg)
   );

   // ---------------- scoreboard state ----------------
   // Event word: {cycle[28:0], kind (01 grant, 10 preempt), index}
   logic [31:0] exp_q[$];
   int          n_total = 0;
   int          n_pass  = 0;
   logic        done = 1'b0;
   logic        wait_expired = 1'b0;

   // ---------------- reference model (timeline view) ----------------
   // The bus is either held (granted or draining) or free. A release at edge
   // E makes the bus free from edge E+GUARD on. A new grant can happen on any
   // later edge where a request is present.
   int   cyc = 0;
   logic m_granted  = 1'b0;
   logic m_draining = 1'b0;
   logic m_preempt  = 1'b0;
   logic m_owner    = 1'b0;
   logic m_last     = 1'b1;
   int   m_wait     = 0;
   int   m_free_edge = 0;

   initial begin : model
      logic [1:0] rq, cs;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_granted = 1'b0; m_draining = 1'b0; m_preempt = 1'b0;
            m_owner = 1'b0; m_last = 1'b1; m_wait = 0; m_free_edge = cyc;
         end else begin
            rq = r_req;
            cs = r_csel;
            cyc = cyc + 1;
            m_preempt = 1'b0;
            if (m_granted) begin
               if (!rq[m_owner]) begin
                  m_granted = 1'b0;
                  m_draining = 1'b1;
               end else if (rq[!m_owner] && cs[m_owner]) begin
                  m_wait = m_wait + 1;
                  if (m_wait == TO) begin
                     m_granted = 1'b0;
                     m_preempt = 1'b1;
                     m_last = m_owner;
                     m_free_edge = cyc + GUARD;
                     exp_q.push_back({cyc[28:0], 2'b10, m_owner});
                  end
               end else begin
                  m_wait = 0;
               end
            end else if (m_draining) begin
               if (cs[m_owner]) begin
                  m_draining = 1'b0;
                  m_last = m_owner;
                  m_free_edge = cyc + GUARD;
               end
            end else if (cyc > m_free_edge && rq != 2'b00) begin
               if (rq == 2'b11) m_owner = !m_last;
               else             m_owner = rq[1];
               m_granted = 1'b1;
               m_wait = 0;
               exp_q.push_back({cyc[28:0], 2'b01, m_owner});
            end
         end
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
   endtask

   task automatic sb_match(input logic [31:0] act);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         check("sb_unexpected_event", act, 32'hFFFF_FFFF);
      end else begin
         e = exp_q.pop_front();
         check("sb_event", act, e);
      end
   endtask

   // Monitor: compares outputs on the falling edge and checks an async reset
   // between edges.
   initial begin : monitor
      logic [1:0] p_gnt;
      logic [9:0] act_v, exp_v;
      logic       e_act;
      p_gnt = 2'b00;
      forever begin
         @(negedge clk or posedge rst);
         if (clk) begin
            // Reset landed mid-cycle: bus must be idle without waiting for an edge.
            #5;
            check("reset_async", 32'({gnt0, gnt1, busy, spi_csel, spi_clk, spi_mosi}),
                  32'(6'b000100));
         end else if ($time > 0) begin
            if (rst) begin
               p_gnt = 2'b00;
            end else begin
               if (gnt0 && !p_gnt[0]) sb_match({cyc[28:0], 2'b01, 1'b0});
               if (gnt1 && !p_gnt[1]) sb_match({cyc[28:0], 2'b01, 1'b1});
               if (preempt)           sb_match({cyc[28:0], 2'b10, owner});
               p_gnt = gnt_w;
            end
            e_act = m_granted || m_draining;
            exp_v = {m_granted && !m_owner, m_granted && m_owner,
                     e_act || (cyc < m_free_edge), m_preempt, m_owner,
                     e_act ? r_csel[m_owner] : 1'b1,
                     e_act ? r_clk[m_owner]  : 1'b0,
                     e_act ? r_mosi[m_owner] : 1'b0,
                     e_act && !m_owner && r_miso,
                     e_act &&  m_owner && r_miso};
            act_v = {gnt0, gnt1, busy, preempt, owner, spi_csel, spi_clk, spi_mosi,
                     spi0_miso, spi1_miso};
            check("cycle_outputs", 32'(act_v), 32'(exp_v));
            if (done) break;
         end
      end
      check("sb_drain", 32'(exp_q.size()), 32'd0);
      check("xfer_found", 32'(wait_expired), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // ---------------- driver tasks ----------------
   // Phase per requester: 0 idle, 1 requesting, 2 owning, 3 releasing.
   int ph[2];
   int cnt[2];

   function automatic int gap();
      if ($urandom_range(0, 5) == 0) return int'($urandom_range(14, 30));
      return int'($urandom_range(1, 8));
   endfunction

   task automatic drive(input int i);
      case (ph[i])
         0: begin
            r_req[i]  = 1'b0;
            r_csel[i] = 1'b1;
            r_clk[i]  = 1'($urandom_range(0, 1));
            r_mosi[i] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
               ph[i] = 1;
               r_req[i] = 1'b1;
            end
         end
         1: begin
            r_req[i]  = 1'b1;
            r_csel[i] = 1'b1;
            r_clk[i]  = 1'($urandom_range(0, 1));
            if (gnt_w[i]) begin
               ph[i] = 2;
               r_clk[i] = 1'b0;
               cnt[i] = int'($urandom_range(1, 4));
            end
         end
         2: begin
            if (!gnt_w[i]) begin
               // Preempted: back off and ask again later.
               r_req[i] = 1'b0; r_csel[i] = 1'b1; r_clk[i] = 1'b0; ph[i] = 0;
            end else if (!r_csel[i]) begin
               r_clk[i]  = ~r_clk[i];
               r_mosi[i] = 1'($urandom_range(0, 1));
               cnt[i] = cnt[i] - 1;
               if (cnt[i] <= 0) begin
                  if ($urandom_range(0, 3) == 0) begin
                     // Drop req with csel still low; keep clocking a while.
                     r_req[i] = 1'b0; ph[i] = 3; cnt[i] = int'($urandom_range(1, 8));
                  end else begin
                     r_csel[i] = 1'b1; r_clk[i] = 1'b0; cnt[i] = gap();
                  end
               end
            end else begin
               cnt[i] = cnt[i] - 1;
               if (cnt[i] <= 0) begin
                  if ($urandom_range(0, 4) == 0) begin
                     r_req[i] = 1'b0; ph[i] = 3; cnt[i] = 0;
                  end else begin
                     r_csel[i] = 1'b0; cnt[i] = int'($urandom_range(2, 12));
                  end
               end
            end
         end
         default: begin
            r_req[i] = 1'b0;
            if (cnt[i] > 0) begin
               r_clk[i]  = ~r_clk[i];
               r_mosi[i] = 1'($urandom_range(0, 1));
               cnt[i] = cnt[i] - 1;
            end else begin
               r_csel[i] = 1'b1; r_clk[i] = 1'b0; ph[i] = 0;
            end
         end
      endcase
   endtask

   task automatic step();
      drive(0);
      drive(1);
      r_miso = 1'($urandom_range(0, 1));
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      logic found;
      ph[0] = 0; ph[1] = 0; cnt[0] = 0; cnt[1] = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Both requesters rise together straight after reset.
      @(posedge clk); #3;
      ph[0] = 1; ph[1] = 1;
      step();

      repeat (6000) begin
         @(posedge clk); #3;
         step();
      end

      // Reset in the middle of a transfer.
      found = 1'b0;
      for (int k = 0; k < 2000 && !found; k++) begin
         @(posedge clk); #3;
         step();
         if (!spi_csel) found = 1'b1;
      end
      if (!found) wait_expired = 1'b1;
      #1 rst = 1'b1;
      r_req = 2'b00; r_csel = 2'b11; r_clk = 2'b00; r_mosi = 2'b00;
      ph[0] = 0; ph[1] = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #2 r_req = 2'b10;
      repeat (3) @(posedge clk);
      #3 r_req = 2'b00;
      repeat (12) @(posedge clk);
      #3 done = 1'b1;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/spi_flash_arbiter.md
Name: spi_flash_arbiter

Overview:
- Shares the single configuration SPI flash between two masters. Requester 0 is the DFU core's SPI engine; requester 1 is a secondary master, such as a boot-image readback/CRC checker.
- Sits between the masters and the board's flash pins: csel, the USRMCLK clock path, mosi and miso.
- Grants ownership with a req/gnt handshake and passes the owner's SPI signals through with zero added latency.
- Guarantees that chip-select is deasserted, plus a guard gap, between owners.

Parameters:
- GUARD_CYCLES, 4, number of clk_48mhz cycles the bus is held idle (csel high) after a release before the next grant; legal range 1..255.
- IDLE_TIMEOUT, 4096, cycles an owner may hold grant with csel high while the other requester waits, before preemption; 0 disables preemption; counter width 16 bits.

Ports:
- clk_48mhz  input  1  system clock, 48 MHz
- reset  input  1  asynchronous, active-high reset
- req0  input  1  requester 0 bus request, level
- gnt0  output  1  requester 0 grant, registered
- spi0_csel  input  1  requester 0 chip-select, active low
- spi0_clk  input  1  requester 0 serial clock
- spi0_mosi  input  1  requester 0 data out
- spi0_miso  output  1  flash data to requester 0
- req1, gnt1, spi1_csel, spi1_clk, spi1_mosi, spi1_miso  same as above, for requester 1
- spi_csel  output  1  to flash chip-select
- spi_clk  output  1  to USRMCLK input
- spi_mosi  output  1  to flash
- spi_miso  input  1  from flash
- busy  output  1  high in any state other than IDLE
- owner  output  1  index of the current or most recent grantee
- preempt  output  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, gnt0=gnt1=0, owner=0, last_owner=1, busy=0, preempt=0.
  - Counters cleared; spi_csel=1, spi_clk=0, spi_mosi=0 immediately.
- Bus mux (combinational from registered state):
  - In GRANT or DRAIN, spi_* = owner's spi*_* and owner's spi*_miso = spi_miso.
  - In all other states, spi_csel=1, spi_clk=0, spi_mosi=0.
  - A non-owner's miso is always 0.
- States: IDLE, GRANT, DRAIN, GUARD.
- IDLE:
  - Only req0 high: owner<=0. Only req1 high: owner<=1.
  - Both high: owner <= ~last_owner (round-robin); the first tie after reset goes to requester 0.
  - Next cycle: state=GRANT and gnt[owner]=1. Latency from req to gnt is 1 cycle.
- GRANT:
  - gnt[owner] held high.
  - req[owner] falls: gnt drops the next cycle and the state goes to DRAIN.
  - Timeout counter:
    - Increments each cycle that the other req is high and owner csel is high.
    - Clears whenever owner csel is low or the other req is low.
  - Counter reaches IDLE_TIMEOUT (nonzero): gnt drops, preempt pulses for 1 cycle, and the state goes directly to GUARD. This is safe because csel is known to be high.
  - req falls in the same cycle the timeout fires: treated as a normal release (DRAIN); no preempt pulse.
- DRAIN:
  - Pass-through continues until owner csel is sampled high.
  - Then go to GUARD. If csel is already high on entry, leave after 1 cycle.
  - An owner that re-raises req during DRAIN is ignored until IDLE.
- GUARD:
  - Bus forced idle for exactly GUARD_CYCLES cycles.
  - Then last_owner<=owner and state=IDLE. Arbitration is evaluated in IDLE on the following cycle.
- Requester rules:
  - Requesters must keep csel high until gnt is seen high.
  - Signals driven while not granted are ignored.
- Reset mid-transfer: bus outputs go idle asynchronously; the flash transaction is abandoned and the requester retries.
- owner holds its value through IDLE; its reset value is 0.

Test Plan:
1. req0 pulsed high alone at cycle 10 -> gnt0=1 at cycle 11; spi_* mirrors spi0_*; gnt1 stays 0.
2. req0 and req1 rise in the same cycle after reset -> gnt0 first. On release: DRAIN, then 4 idle cycles with csel high, then gnt1 five cycles after csel high.
3. Owner drops req0 while spi0_csel is low, with 8 more clocks toggling -> spi_clk keeps following spi0_clk until csel rises, then the bus is idle.
4. IDLE_TIMEOUT=16: req0 held with csel high and req1 high -> preempt pulse at the 16th waiting cycle, gnt0=0, and gnt1 GUARD_CYCLES+1 later.
5. Transfer activity (csel low) every 10 cycles with IDLE_TIMEOUT=16 -> no preemption.
6. Assert reset mid-transfer -> spi_csel=1, gnt0=gnt1=0 in the same cycle, without waiting for a clock edge. After release, req1 alone -> gnt1 one cycle later.
